snake_engine: RTL
=================

# snake_engine

Parametrised snake body engine for the VGA snake game. It holds every segment's grid coordinates in a shift register and advances the snake one cell per step period. It also applies direction requests with reversal rejection, grows on request up to a configurable maximum, and detects wall and self collisions. The VGA controller queries it per grid cell to learn whether that cell is head, body or empty. It sits between the key/direction logic and the VGA controller, alongside the apple generator and score counter, all on the 25 MHz pixel clock.

## Interface
Parameters:
- GRID_W, 40, grid columns
- GRID_H, 30, grid rows
- X_W, 6, x coordinate width; must satisfy 2^X_W ≥ GRID_W
- Y_W, 5, y coordinate width; must satisfy 2^Y_W ≥ GRID_H
- MAX_LEN, 16, maximum segment count; must be ≥ 2
- INIT_LEN, 3, length after reset or restart; 2 ≤ INIT_LEN ≤ MAX_LEN, INIT_LEN ≤ GRID_W/2
- STEP_DIV, 12_500_000, clock cycles per move (0.5 s at 25 MHz); must be ≥ 2

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: IDLE→RUN, or DEAD→restart
- dir_valid  in  1  dir_req is valid this cycle
- dir_req  in  2  requested direction: 00 right, 01 left, 10 down, 11 up
- grow  in  1  single-cycle pulse: apple eaten
- query_x  in  X_W  grid column queried by the VGA controller
- query_y  in  Y_W  grid row queried by the VGA controller
- query_hit  out  2  cell content: 00 empty, 01 head, 10 body
- head_x  out  X_W  head column
- head_y  out  Y_W  head row
- length  out  $clog2(MAX_LEN+1)  active segment count
- step_pulse  out  1  one-cycle strobe on each committed move
- state  out  2  00 IDLE, 01 RUN, 10 DEAD
- hit_wall  out  1  sticky wall-collision flag
- hit_body  out  1  sticky self-collision flag

## Operation
- Storage: seg_x/seg_y arrays of MAX_LEN entries. Index 0 is the head. Only indices below `length` are active.
- Init (reset, or restart from DEAD):
  - seg[i] = (GRID_W/2 − i, GRID_H/2) for every i.
  - length = INIT_LEN, committed direction = right, pending direction = right, grow_pending = 0.
  - Step counter = 0, both hit flags = 0.
- IDLE: snake is frozen. `start` → RUN, with the step counter cleared.
- RUN: step counter counts 0..STEP_DIV−1. When it reaches STEP_DIV−1 (step edge):
  - Next head = seg[0] moved one cell in the pending direction.
  - Wall check: next x ≥ GRID_W, next y ≥ GRID_H, or underflow below 0 is a wall hit.
  - Body check: next head is compared with seg[0..length−2]. When grow_pending is set, seg[length−1] is also included, because the tail does not vacate.
  - Wall hit → hit_wall=1, state DEAD, no shift.
  - Body hit → hit_body=1, state DEAD, no shift.
  - No hit → seg[i] ← seg[i−1] and seg[0] ← next head; committed direction ← pending direction; step_pulse=1.
  - Also on a no-hit step: if grow_pending, length ← min(length+1, MAX_LEN) and grow_pending cleared. At saturation the grow is consumed and discarded.
- Direction rule (any state):
  - dir_valid with dir_req opposite the committed direction is ignored. Opposite means bit1 equal and bit0 different.
  - Otherwise pending direction ← dir_req. The last accepted request before a step wins.
- grow: sets grow_pending in RUN only. It is ignored in IDLE and DEAD.
- DEAD: segments, length and flags are frozen. `start` → Init and RUN on the same edge.
- Query: query_hit is registered. Head match has priority over body match. Only active segments are compared.
- Simultaneous events:
  - grow on the step edge is latched for the next step.
  - dir_valid on the step edge is not used by the current step.
  - start in RUN is ignored.
- rst has priority over every input at any point mid-operation.

## Timing
- Reset values:
  - state=IDLE, length=INIT_LEN.
  - head_x=GRID_W/2, head_y=GRID_H/2.
  - query_hit=00, step_pulse=0, hit_wall=0, hit_body=0.
- First step occurs STEP_DIV cycles after the `start` edge.
- head_x, head_y, length and step_pulse update on the step edge and are visible the following cycle.
- state and the hit flags update on the collision edge.
- query_hit latency is 1 cycle from query_x/query_y.

## Configuration
- SNAKE_WRAP_EN defined:
  - Wall collisions are disabled.
  - x wraps: GRID_W−1 → 0 and 0 → GRID_W−1. y wraps the same way with GRID_H.
  - hit_wall stays 0.
- SNAKE_WRAP_EN undefined: wall collision kills, as described under Operation.

## Test plan
All scenarios use GRID_W=8, GRID_H=6, MAX_LEN=8, INIT_LEN=2, STEP_DIV=4.
- Reset, then query (4,3), (3,3) and (0,0) → query_hit 01, 10, 00, each one cycle later. state=00, length=2.
- Start, no input → head (5,3), (6,3) and (7,3) at 4-cycle intervals with step_pulse each time. The 4th step sets hit_wall=1 and state=10, with head held at (7,3). With SNAKE_WRAP_EN the 4th step instead gives head (0,3) and state=01.
- In RUN, dir_req=left → ignored and head keeps moving right. dir_req=down then dir_req=left inside one period → the step moves down to y=4.
- Start, grow pulse before each of the first 3 steps → length 3, 4, 5 and head (7,3). Then down, left, up on successive periods → head (7,4), then (6,4), then hit_body=1 and state=10 with head held at (6,4).
- At length=MAX_LEN, grow then step → length stays 8 and grow_pending is cleared.
- In DEAD, pulse start → next cycle shows state=01, head (4,3), length=2, flags 0. Assert rst mid-RUN → IDLE with reset values next cycle.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: body engine for the VGA snake game.
//
// Keeps every segment coordinate in a shift register (index 0 is the head).
// Each step period it moves the snake one cell, applies direction requests
// with reversal rejection, grows on request up to MAX_LEN, and detects wall
// and self collisions. The VGA controller queries it per grid cell.
//
// Optional feature macro: SNAKE_WRAP_EN
//   defined   - the playfield wraps at its edges and walls never kill.
//   undefined - leaving the grid is a wall hit.
//
// Ports:
//   clk, rst          25 MHz clock, synchronous active-high reset
//   start             pulse: IDLE->RUN, or DEAD->restart
//   dir_valid/dir_req direction request (00 R, 01 L, 10 D, 11 U)
//   grow              pulse: apple eaten (honoured in RUN only)
//   query_x/query_y   cell queried by the VGA controller
//   query_hit         registered cell content (00 empty, 01 head, 10 body)
//   head_x/head_y     head position
//   length            active segment count
//   step_pulse        one-cycle strobe on every committed move
//   state             00 IDLE, 01 RUN, 10 DEAD
//   hit_wall/hit_body sticky collision flags
module snake_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int STEP_DIV = 12_500_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir_req,
  input  logic                           grow,
  input  logic [X_W-1:0]                 query_x,
  input  logic [Y_W-1:0]                 query_y,
  output logic [1:0]                     query_hit,
  output logic [X_W-1:0]                 head_x,
  output logic [Y_W-1:0]                 head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           step_pulse,
  output logic [1:0]                     state,
  output logic                           hit_wall,
  output logic                           hit_body
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(STEP_DIV);

  localparam logic [X_W-1:0]   X_MAX      = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX      = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_ONE      = X_W'(1);
  localparam logic [Y_W-1:0]   Y_ONE      = Y_W'(1);
  localparam logic [Y_W-1:0]   INIT_Y     = Y_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0] LEN_INIT   = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10
  } state_e;

  // Start column of segment idx; entries beyond GRID_W/2 wrap but are never active.
  function automatic logic [X_W-1:0] init_x(input int idx);
    init_x = X_W'(GRID_W / 2 - idx);
  endfunction

  state_e             state_q, state_d;
  logic [X_W-1:0]     seg_x_q [MAX_LEN];
  logic [X_W-1:0]     seg_x_d [MAX_LEN];
  logic [Y_W-1:0]     seg_y_q [MAX_LEN];
  logic [Y_W-1:0]     seg_y_d [MAX_LEN];
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         dir_cmt_q, dir_cmt_d;
  logic [1:0]         dir_pend_q, dir_pend_d;
  logic               grow_pend_q, grow_pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_pulse_q, step_pulse_d;
  logic               hit_wall_q, hit_wall_d;
  logic               hit_body_q, hit_body_d;
  logic [1:0]         query_hit_q, query_hit_d;

  logic [X_W-1:0]     nxt_x_s;
  logic [Y_W-1:0]     nxt_y_s;
  logic               wall_s;
  logic               body_s;
  logic               q_head_s;
  logic               q_body_s;
  int                 len_i;

  assign len_i = int'(len_q);

  // Candidate head one cell away in the pending direction, plus edge detection.
  always_comb begin
    nxt_x_s = seg_x_q[0];
    nxt_y_s = seg_y_q[0];
    wall_s  = 1'b0;
    case (dir_pend_q)
      DIR_RIGHT: begin
        if (seg_x_q[0] == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          nxt_x_s = {X_W{1'b0}};
`else
          wall_s  = 1'b1;
`endif
        end else begin
          nxt_x_s = seg_x_q[0] + X_ONE;
        end
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == {X_W{1'b0}}) begin
`ifdef SNAKE_WRAP_EN
          nxt_x_s = X_MAX;
`else
          wall_s  = 1'b1;
`endif
        end else begin
          nxt_x_s = seg_x_q[0] - X_ONE;
        end
      end
      DIR_DOWN: begin
        if (seg_y_q[0] == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          nxt_y_s = {Y_W{1'b0}};
`else
          wall_s  = 1'b1;
`endif
        end else begin
          nxt_y_s = seg_y_q[0] + Y_ONE;
        end
      end
      DIR_UP: begin
        if (seg_y_q[0] == {Y_W{1'b0}}) begin
`ifdef SNAKE_WRAP_EN
          nxt_y_s = Y_MAX;
`else
          wall_s  = 1'b1;
`endif
        end else begin
          nxt_y_s = seg_y_q[0] - Y_ONE;
        end
      end
      default: begin
        wall_s = 1'b0;
      end
    endcase
  end

  // Self-collision: the tail only counts when it will not vacate (growth pending).
  always_comb begin
    body_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((i < len_i - 1) || (grow_pend_q && (i == len_i - 1))) &&
          (seg_x_q[i] == nxt_x_s) && (seg_y_q[i] == nxt_y_s)) begin
        body_s = 1'b1;
      end else begin
        body_s = body_s;
      end
    end
  end

  // Cell query against active segments; head wins over body.
  always_comb begin
    q_head_s = 1'b0;
    q_body_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < len_i) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
        if (i == 0) begin
          q_head_s = 1'b1;
        end else begin
          q_body_s = 1'b1;
        end
      end else begin
        q_head_s = q_head_s;
      end
    end
    query_hit_d = q_head_s ? 2'b01 : (q_body_s ? 2'b10 : 2'b00);
  end

  // Next-state logic: direction filter, FSM, stepping, growth and restart.
  always_comb begin
    state_d      = state_q;
    seg_x_d      = seg_x_q;
    seg_y_d      = seg_y_q;
    len_d        = len_q;
    dir_cmt_d    = dir_cmt_q;
    dir_pend_d   = dir_pend_q;
    grow_pend_d  = grow_pend_q;
    cnt_d        = cnt_q;
    step_pulse_d = 1'b0;
    hit_wall_d   = hit_wall_q;
    hit_body_d   = hit_body_q;

    // Reversal is judged against the direction actually travelled last step.
    if (dir_valid && !((dir_req[1] == dir_cmt_q[1]) && (dir_req[0] != dir_cmt_q[0]))) begin
      dir_pend_d = dir_req;
    end else begin
      dir_pend_d = dir_pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (grow) begin
          grow_pend_d = 1'b1;
        end else begin
          grow_pend_d = grow_pend_q;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (wall_s) begin
            hit_wall_d = 1'b1;
            state_d    = S_DEAD;
          end else if (body_s) begin
            hit_body_d = 1'b1;
            state_d    = S_DEAD;
          end else begin
            seg_x_d[0] = nxt_x_s;
            seg_y_d[0] = nxt_y_s;
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            dir_cmt_d    = dir_pend_q;
            step_pulse_d = 1'b1;
            // A grow arriving on this very edge is kept for the next step.
            grow_pend_d  = grow;
            if (grow_pend_q && (len_q < LEN_MAX)) begin
              len_d = len_q + LEN_ONE;
            end else begin
              len_d = len_q;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DEAD: begin
        if (start) begin
          state_d     = S_RUN;
          for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = init_x(i);
            seg_y_d[i] = INIT_Y;
          end
          len_d       = LEN_INIT;
          dir_cmt_d   = DIR_RIGHT;
          dir_pend_d  = DIR_RIGHT;
          grow_pend_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          hit_wall_d  = 1'b0;
          hit_body_d  = 1'b0;
        end else begin
          state_d = S_DEAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= INIT_Y;
      end
      len_q        <= LEN_INIT;
      dir_cmt_q    <= DIR_RIGHT;
      dir_pend_q   <= DIR_RIGHT;
      grow_pend_q  <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      step_pulse_q <= 1'b0;
      hit_wall_q   <= 1'b0;
      hit_body_q   <= 1'b0;
      query_hit_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      seg_x_q      <= seg_x_d;
      seg_y_q      <= seg_y_d;
      len_q        <= len_d;
      dir_cmt_q    <= dir_cmt_d;
      dir_pend_q   <= dir_pend_d;
      grow_pend_q  <= grow_pend_d;
      cnt_q        <= cnt_d;
      step_pulse_q <= step_pulse_d;
      hit_wall_q   <= hit_wall_d;
      hit_body_q   <= hit_body_d;
      query_hit_q  <= query_hit_d;
    end
  end

  assign query_hit  = query_hit_q;
  assign head_x     = seg_x_q[0];
  assign head_y     = seg_y_q[0];
  assign length     = len_q;
  assign step_pulse = step_pulse_q;
  assign state      = state_q;
  assign hit_wall   = hit_wall_q;
  assign hit_body   = hit_body_q;

endmodule
